wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/sys_defs.sv | 28 ++
 rtl/wb_arbiter_pkg.sv | 10 +
 rtl/rr_multi_grant.sv | 66 ++++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared system type definitions used by the writeback path.
// Provides the execute-stage result packet, the CDB broadcast record and
// the machine word / instruction types.
package sys_defs;

  localparam int unsigned XLEN_W    = 32;
  localparam int unsigned ROB_TAG_W = 5;

  typedef logic [XLEN_W-1:0] XLEN;
  typedef logic [31:0]       INST;

  // Result produced by a functional unit at the end of execute.
  typedef struct packed {
    logic                 valid;
    XLEN                  value;
    logic [ROB_TAG_W-1:0] rob_tag;
    INST                  inst;
    XLEN                  NPC;
  } EX_WR_PACKET;

  // One common-data-bus broadcast channel.
  typedef struct packed {
    logic                 valid;
    XLEN                  value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

endpackage

// File: rtl/wb_arbiter_pkg.sv
// Helpers shared by the writeback arbiter and its grant logic.
package wb_arbiter_pkg;

  // Round-robin pointer width; at least one bit so a single-FU build still
  // has a legal vector.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Multi-grant round-robin selector (pure combinational).
// Scans requesters starting at ptr, wrapping modulo FU_NUM, and grants up to
// CDB_NUM of them in scan order.
// Ports:
//   req      - per-FU request (held entries)
//   ptr      - scan start index
//   flush    - suppress all grants, pointer holds
//   grant    - per-FU grant vector
//   ch_idx   - FU index driving each channel
//   ch_valid - channel carries a grant
//   next_ptr - one past the last granted FU, or ptr when nothing is granted
module rr_multi_grant
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM  = 4,
  parameter int unsigned CDB_NUM = 2,
  parameter int unsigned PTR_W   = ptr_width(FU_NUM)
) (
  input  logic [FU_NUM-1:0]  req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               flush,
  output logic [FU_NUM-1:0]  grant,
  output logic [PTR_W-1:0]   ch_idx [CDB_NUM],
  output logic [CDB_NUM-1:0] ch_valid,
  output logic [PTR_W-1:0]   next_ptr
);

  always_comb begin
    int unsigned pos;
    int unsigned n_grant;
    int unsigned last;
    logic [PTR_W-1:0] pos_idx;

    grant    = '0;
    ch_valid = '0;
    for (int unsigned k = 0; k < CDB_NUM; k++) begin
      ch_idx[k] = '0;
    end
    pos      = 0;
    pos_idx  = '0;
    n_grant  = 0;
    last     = 0;

    for (int unsigned off = 0; off < FU_NUM; off++) begin
      // Modulo wrap by subtraction: FU_NUM need not be a power of two.
      pos = 32'(ptr) + off;
      if (pos >= FU_NUM) begin
        pos = pos - FU_NUM;
      end
      pos_idx = pos[PTR_W-1:0];
      if (!flush && req[pos_idx] && (n_grant < CDB_NUM)) begin
        grant[pos_idx]    = 1'b1;
        ch_idx[n_grant]   = pos_idx;
        ch_valid[n_grant] = 1'b1;
        n_grant           = n_grant + 1;
        last              = pos;
      end
    end

    next_ptr = ptr;
    if (n_grant != 0) begin
      next_ptr = ((last + 1) >= FU_NUM) ? '0 : PTR_W'(last + 1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers one result per functional unit and broadcasts
// up to CDB_NUM of them per cycle on the common data bus, round-robin.
// Results are only broadcast from the holding registers, so every result
// spends at least one cycle buffered.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   flush         - squash buffered results and incoming packets
//   ex_packet_in  - per-FU result packet
//   ex_ready      - per-FU accept (depends only on state and flush)
//   cdb           - broadcast channels, unused channels zeroed
//   wr_inst       - instruction of each channel, 0 when invalid
//   wr_NPC        - NPC of each channel, 0 when invalid
// CDB_NUM must lie in 1..FU_NUM.
module wb_arbiter
  import sys_defs::*;
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM  = 4,
  parameter int unsigned CDB_NUM = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  EX_WR_PACKET       ex_packet_in [FU_NUM],
  output logic [FU_NUM-1:0] ex_ready,
  output CDB_DATA           cdb          [CDB_NUM],
  output INST               wr_inst      [CDB_NUM],
  output XLEN               wr_NPC       [CDB_NUM]
);

  localparam int unsigned PtrW = ptr_width(FU_NUM);

  logic [FU_NUM-1:0]    held_q, held_d;
  logic [FU_NUM-1:0]    grant;
  logic [FU_NUM-1:0]    accept;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      ch_idx [CDB_NUM];
  logic [CDB_NUM-1:0]   ch_valid;

  // Stored packet fields; the valid bit lives in held_q.
  XLEN                  value_q [FU_NUM];
  logic [ROB_TAG_W-1:0] tag_q   [FU_NUM];
  INST                  inst_q  [FU_NUM];
  XLEN                  npc_q   [FU_NUM];

  rr_multi_grant #(
    .FU_NUM  (FU_NUM),
    .CDB_NUM (CDB_NUM),
    .PTR_W   (PtrW)
  ) u_grant (
    .req      (held_q),
    .ptr      (rr_ptr_q),
    .flush    (flush),
    .grant    (grant),
    .ch_idx   (ch_idx),
    .ch_valid (ch_valid),
    .next_ptr (rr_ptr_d)
  );

  // A slot being drained this cycle can take a new packet in the same cycle.
  always_comb begin
    ex_ready = ~held_q | grant | {FU_NUM{flush}};
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      accept[i] = ex_packet_in[i].valid & ex_ready[i] & ~flush;
    end
  end

  // Flush drops everything; otherwise drain granted slots, then refill.
  always_comb begin
    held_d = '0;
    if (!flush) begin
      held_d = (held_q & ~grant) | accept;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind held_q.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      if (accept[i]) begin
        value_q[i] <= ex_packet_in[i].value;
        tag_q[i]   <= ex_packet_in[i].rob_tag;
        inst_q[i]  <= ex_packet_in[i].inst;
        npc_q[i]   <= ex_packet_in[i].NPC;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CDB_NUM; k++) begin
      cdb[k]     = '0;
      wr_inst[k] = '0;
      wr_NPC[k]  = '0;
      if (ch_valid[k]) begin
        cdb[k].valid   = 1'b1;
        cdb[k].value   = value_q[ch_idx[k]];
        cdb[k].rob_tag = tag_q[ch_idx[k]];
        wr_inst[k]     = inst_q[ch_idx[k]];
        wr_NPC[k]      = npc_q[ch_idx[k]];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (FU_NUM=4, CDB_NUM=2): directed
// scenarios followed by random traffic, all checked against a slot-level
// reference model.
module tb_wb_arbiter;
  import sys_defs::*;

  localparam int FU  = 4;
  localparam int CDB = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  EX_WR_PACKET    ex_packet_in [FU];
  logic [FU-1:0]  ex_ready;
  CDB_DATA        cdb     [CDB];
  INST            wr_inst [CDB];
  XLEN            wr_NPC  [CDB];

  always #5 clock = ~clock;

  wb_arbiter #(
    .FU_NUM  (FU),
    .CDB_NUM (CDB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .ex_packet_in (ex_packet_in),
    .ex_ready     (ex_ready),
    .cdb          (cdb),
    .wr_inst      (wr_inst),
    .wr_NPC       (wr_NPC)
  );

  int tests = 0;
  int fails = 0;

  // FU side: packet each FU is offering (held until accepted).
  EX_WR_PACKET src [FU];
  bit          refill_mode = 1'b0;
  int          tag_ctr = 0;

  // Reference model: which slots hold a result, what they hold, scan start.
  bit          m_held [FU];
  EX_WR_PACKET m_pkt  [FU];
  int          m_ptr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic EX_WR_PACKET mk(input int tag);
    EX_WR_PACKET p;
    p.valid   = 1'b1;
    p.value   = $urandom;
    p.rob_tag = ROB_TAG_W'(tag);
    p.inst    = $urandom;
    p.NPC     = $urandom;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FU; i++) m_held[i] = 1'b0;
    m_ptr = 0;
  endtask

  function automatic bit any_held();
    for (int i = 0; i < FU; i++) if (m_held[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input string tag);
    int            order[$];
    bit            granted [FU];
    logic [FU-1:0] exp_ready;
    logic [127:0]  exp_ch, obs_ch;
    for (int i = 0; i < FU; i++) ex_packet_in[i] = src[i];
    #1;
    // Held slots in wrap-around order from the pointer; the first CDB win.
    if (!flush && !reset) begin
      for (int off = 0; off < FU; off++) begin
        int i = (m_ptr + off) % FU;
        if (m_held[i] && order.size() < CDB) order.push_back(i);
      end
    end
    for (int i = 0; i < FU; i++) granted[i] = 1'b0;
    foreach (order[k]) granted[order[k]] = 1'b1;
    for (int i = 0; i < FU; i++) exp_ready[i] = !m_held[i] || granted[i] || flush;
    check({tag, ".ready"}, 128'(ex_ready), 128'(exp_ready));
    for (int k = 0; k < CDB; k++) begin
      exp_ch = '0;
      if (k < order.size()) begin
        EX_WR_PACKET p = m_pkt[order[k]];
        exp_ch = 128'({1'b1, p.value, p.rob_tag, p.inst, p.NPC});
      end
      obs_ch = 128'({cdb[k].valid, cdb[k].value, cdb[k].rob_tag, wr_inst[k], wr_NPC[k]});
      check($sformatf("%s.ch%0d", tag, k), obs_ch, exp_ch);
    end
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < FU; i++) begin
        if (flush || granted[i]) m_held[i] = 1'b0;
      end
      for (int i = 0; i < FU; i++) begin
        if (src[i].valid && exp_ready[i]) begin
          if (!flush) begin
            m_held[i] = 1'b1;
            m_pkt[i]  = src[i];
          end
          if (refill_mode) src[i] = mk(i + 1);
          else src[i].valid = 1'b0;
        end
      end
      if (!flush && order.size() > 0) m_ptr = (order[order.size()-1] + 1) % FU;
    end
    @(negedge clock);
    check({tag, ".ptr"}, 128'(dut.rr_ptr_q), 128'(m_ptr));
  endtask

  initial begin
    EX_WR_PACKET none;
    int saved_ptr;
    none = '0;
    model_reset();

    // Reset with every FU offering a result: nothing broadcast, all accepted
    // right after release, then FU0/FU1 broadcast first.
    refill_mode = 1'b1;
    for (int i = 0; i < FU; i++) src[i] = mk(i + 1);
    for (int i = 0; i < FU; i++) ex_packet_in[i] = src[i];
    @(negedge clock);
    cycle("rst0");
    cycle("rst1");
    reset = 1'b0;
    cycle("rel");
    check("rst.cdb0_tag", 128'({cdb[0].valid, cdb[0].rob_tag}), 128'({1'b1, 5'd1}));
    check("rst.cdb1_tag", 128'({cdb[1].valid, cdb[1].rob_tag}), 128'({1'b1, 5'd2}));

    // Continuous contention: pairs {0,1},{2,3} alternate.
    for (int c = 0; c < 6; c++) cycle($sformatf("cont%0d", c));

    // Drain.
    refill_mode = 1'b0;
    for (int c = 0; c < 4; c++) cycle($sformatf("drain%0d", c));
    check("drain.empty", 128'(dut.held_q), 128'(0));

    // Single source: FU2 only.
    src[2] = mk(5);
    src[2].value = 32'hDEAD;
    cycle("ss0");
    check("ss.cdb0", 128'({cdb[0].valid, cdb[0].value, cdb[0].rob_tag}),
          128'({1'b1, 32'hDEAD, 5'd5}));
    check("ss.cdb1_valid", 128'(cdb[1].valid), 128'(0));
    cycle("ss1");
    check("ss.ptr", 128'(dut.rr_ptr_q), 128'(3));

    // Backpressure: get FU1,2,3 held with the pointer at 2.
    src[1] = mk(6);
    cycle("bp0");
    src[1] = mk(7);
    src[2] = mk(8);
    src[3] = mk(9);
    cycle("bp1");
    check("bp.ptr", 128'(dut.rr_ptr_q), 128'(2));
    src[1] = mk(10);
    check("bp.ready1", 128'(ex_ready[1]), 128'(0));
    cycle("bp2");
    check("bp.pending", 128'(src[1].valid), 128'(1));
    cycle("bp3");
    for (int c = 0; c < 3; c++) cycle($sformatf("bpd%0d", c));

    // Flush with three held and FU0 offering a new packet.
    src[1] = mk(11);
    src[2] = mk(12);
    src[3] = mk(13);
    cycle("fl0");
    src[0] = mk(14);
    saved_ptr = m_ptr;
    flush = 1'b1;
    cycle("fl1");
    flush = 1'b0;
    cycle("fl2");
    check("fl.ptr_hold", 128'(dut.rr_ptr_q), 128'(saved_ptr));
    check("fl.no_bcast", 128'({cdb[0].valid, cdb[1].valid}), 128'(0));

    // Asynchronous reset pulse between edges with entries held.
    for (int i = 0; i < FU; i++) src[i] = mk(15 + i);
    cycle("ar0");
    for (int i = 0; i < FU; i++) ex_packet_in[i] = none;
    #1 reset = 1'b1;
    #1;
    check("ar.cdb_valid", 128'({cdb[0].valid, cdb[1].valid}), 128'(0));
    check("ar.ready", 128'(ex_ready), 128'({FU{1'b1}}));
    #1 reset = 1'b0;
    model_reset();
    @(negedge clock);
    for (int c = 0; c < 2; c++) cycle($sformatf("ar%0d", c + 1));

    // Random traffic with occasional flush.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < FU; i++) begin
        if (!src[i].valid && ($urandom_range(2) == 0)) begin
          src[i] = mk(tag_ctr % 32);
          tag_ctr++;
        end
      end
      flush = ($urandom_range(19) == 0);
      cycle($sformatf("rnd%0d", c));
    end
    flush = 1'b0;
    for (int i = 0; i < FU; i++) src[i].valid = 1'b0;
    for (int c = 0; c < 4; c++) cycle($sformatf("end%0d", c));
    check("end.empty", 128'(any_held()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
